axis_pkt_store_fwd: RTL and testbench

//  Store-and-forward AXI-Stream packet FIFO for one NoC endpoint, placed on the user clock directly upstream of the ring ingress shim.

---
 rtl/axis_pkt_store_fwd.sv | 86 ++++++++
 tb/tb_axis_pkt_store_fwd.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_store_fwd.sv
// Store-and-forward AXI-Stream packet FIFO with a first-word-fall-through head.
// A packet too long to hold whole is forwarded cut-through so the FIFO cannot deadlock.
module axis_pkt_store_fwd #(
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int DEPTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic [TID_WIDTH-1:0]       s_axis_tid,
  input  logic [TDEST_WIDTH-1:0]     s_axis_tdest,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [TID_WIDTH-1:0]       m_axis_tid,
  output logic [TDEST_WIDTH-1:0]     m_axis_tdest,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       cut_through
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = TID_WIDTH + TDEST_WIDTH + 1 + TDATA_WIDTH;

  typedef enum logic {STORE, CUT} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t        state;
  logic          wr, rd;

  // Gating with rst keeps both handshakes idle during reset, even before the first edge.
  assign s_axis_tready = ~rst & (occupancy != CW'(DEPTH));
  assign m_axis_tvalid = ~rst & (occupancy != '0) & ((pkt_count != '0) | cut_through);
  assign wr = s_axis_tvalid & s_axis_tready;
  assign rd = m_axis_tvalid & m_axis_tready;

  assign {m_axis_tid, m_axis_tdest, m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {s_axis_tid, s_axis_tdest, s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      pkt_count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + CW'(wr) - CW'(rd);
      pkt_count <= pkt_count + CW'(wr & s_axis_tlast) - CW'(rd & m_axis_tlast);
    end
  end

  // Full with no complete packet means the head packet can never finish in STORE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= STORE;
      cut_through <= 1'b0;
    end else begin
      case (state)
        STORE: if (occupancy == CW'(DEPTH) && pkt_count == '0) begin
          state       <= CUT;
          cut_through <= 1'b1;
        end
        CUT: if (rd & m_axis_tlast) begin
          state       <= STORE;
          cut_through <= 1'b0;
        end
        default: begin
          state       <= STORE;
          cut_through <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_pkt_store_fwd.sv
// Directed and randomized checks of axis_pkt_store_fwd against a queue-based packet model.
module tb_axis_pkt_store_fwd;
  localparam int DEPTH = 8;
  localparam int DW    = 64;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [1:0]    tid;
    logic [3:0]    tdest;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 0;
  logic          rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [1:0]    s_tid;
  logic [3:0]    s_tdest;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [1:0]    m_tid;
  logic [3:0]    m_tdest;
  logic [CW-1:0] occupancy, pkt_count;
  logic          cut_through;

  axis_pkt_store_fwd #(.TID_WIDTH(2), .TDEST_WIDTH(4), .TDATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
    .occupancy(occupancy), .pkt_count(pkt_count), .cut_through(cut_through)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    passes = 0;
  beat_t in_q[$];   // beats still to be offered
  beat_t mq[$];     // beats held by the FIFO, in order
  int    complete = 0;
  bit    cut = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin passes++; end
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic add_pkt(input int len);
    beat_t b;
    b.tid   = 2'($urandom);
    b.tdest = 4'($urandom);
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.last = (i == len - 1);
      in_q.push_back(b);
    end
  endtask

  // One clock: drive, compare against the model, clock, then advance the model.
  task automatic cycle(input int vpct, input int rpct);
    bit    exp_tready, exp_mvalid, wr, rd;
    beat_t head;
    if (in_q.size() > 0 && $urandom_range(99) < vpct) begin
      s_tvalid = 1;
      {s_tid, s_tdest, s_tlast, s_tdata} = in_q[0];
    end else begin
      s_tvalid = 0;
      {s_tid, s_tdest, s_tlast, s_tdata} = {$urandom, $urandom, $urandom};
    end
    m_tready = ($urandom_range(99) < rpct);
    #1;
    exp_tready = !rst && mq.size() != DEPTH;
    exp_mvalid = !rst && mq.size() != 0 && (complete != 0 || cut);
    chk("s_tready", s_tready, exp_tready);
    chk("m_tvalid", m_tvalid, exp_mvalid);
    chk("occupancy", occupancy, mq.size());
    chk("pkt_count", pkt_count, complete);
    chk("cut_through", cut_through, cut);
    if (exp_mvalid) chk("m_beat", {m_tid, m_tdest, m_tlast, m_tdata}, mq[0]);
    wr = s_tvalid && exp_tready;
    rd = exp_mvalid && m_tready;
    @(posedge clk); #1;
    if (rst) begin
      mq.delete();
      complete = 0;
      cut = 0;
    end else begin
      if (!cut && mq.size() == DEPTH && complete == 0) cut = 1;
      else if (cut && rd && mq[0].last) cut = 0;
      if (rd) begin
        head = mq.pop_front();
        if (head.last) complete--;
      end
      if (wr) begin
        head = in_q.pop_front();
        mq.push_back(head);
        if (head.last) complete++;
      end
    end
  endtask

  task automatic drain(input int vpct, input int rpct, input int max);
    for (int i = 0; i < max && (in_q.size() > 0 || mq.size() > 0); i++) cycle(vpct, rpct);
    chk("drain_done", in_q.size() + mq.size(), 0);
  endtask

  initial begin
    rst = 1; s_tvalid = 0; m_tready = 0;
    s_tdata = '0; s_tlast = 0; s_tid = '0; s_tdest = '0;
    @(posedge clk); #1;
    cycle(0, 0);
    cycle(0, 0);
    rst = 0;

    // single 3-beat packet with the sink always ready
    add_pkt(3);
    drain(100, 100, 20);

    // fill with two 4-beat packets while the sink stalls
    add_pkt(4); add_pkt(4);
    repeat (10) cycle(100, 0);
    chk("fill_occ", occupancy, 8);
    chk("fill_pkts", pkt_count, 2);
    chk("fill_tready", s_tready, 0);
    chk("fill_cut", cut_through, 0);
    drain(100, 100, 20);

    // tlast in and tlast out on the same edge
    add_pkt(1);
    cycle(100, 0); cycle(0, 0);
    add_pkt(1);
    cycle(100, 100);
    chk("conc_pkts", pkt_count, 1);
    chk("conc_occ", occupancy, 1);
    drain(100, 100, 10);

    // oversize 12-beat packet forces cut-through
    add_pkt(12);
    repeat (8) cycle(100, 0);
    chk("over_full", occupancy, 8);
    chk("over_cut_pre", cut_through, 0);
    cycle(100, 100);
    chk("over_cut_on", cut_through, 1);
    drain(100, 100, 40);
    chk("over_cut_off", cut_through, 0);

    // reset after 2 of 5 beats flushes the partial packet
    add_pkt(5);
    cycle(100, 100); cycle(100, 100);
    rst = 1;
    cycle(0, 0);
    rst = 0;
    in_q.delete();
    chk("rst_occ", occupancy, 0);
    chk("rst_mvalid", m_tvalid, 0);
    add_pkt(2);
    drain(100, 100, 20);

    // random traffic with 50% sink backpressure
    for (int p = 0; p < 100; p++) add_pkt($urandom_range(1, 8));
    drain(70, 50, 5000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
